// File: rtl/alu_sequencer.sv
// Single-issue instruction sequencer for an external ALU with ALU_LAT cycles of latency.
// Owns an 8x16 register file (r0 hard-wired to zero) and writes back one result per instruction.
module alu_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          instr_op,
  input  logic [2:0]          instr_rd,
  input  logic [2:0]          instr_rs1,
  input  logic [2:0]          instr_rs2,
  input  logic                instr_use_imm,
  input  logic [15:0]         instr_imm,
  output logic [3:0]          alu_opcode,
  output logic signed [15:0]  alu_a,
  output logic signed [15:0]  alu_b,
  input  logic [15:0]         alu_result,
  input  logic                alu_carry,
  input  logic                alu_sign,
  input  logic                alu_overflow,
  output logic [3:0]          flags,
  output logic                wb_valid,
  output logic [2:0]          wb_rd,
  output logic [15:0]         wb_data,
  input  logic [2:0]          dbg_rd_addr,
  output logic [15:0]         dbg_rd_data
);

  localparam int         DATA_W = 16;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                    state_q;
  logic [2:0]                cnt_q;
  logic [2:0]                rd_q;
  logic signed [DATA_W-1:0]  regs_q [8];
  logic [3:0]                alu_opcode_q;
  logic signed [DATA_W-1:0]  alu_a_q;
  logic signed [DATA_W-1:0]  alu_b_q;
  logic [3:0]                flags_q;
  logic                      wb_valid_q;
  logic [2:0]                wb_rd_q;
  logic [DATA_W-1:0]         wb_data_q;

  // Operands come from the register contents before this edge's writeback.
  logic signed [DATA_W-1:0]  alu_a_d;
  logic signed [DATA_W-1:0]  alu_b_d;

  assign alu_a_d = regs_q[instr_rs1];
  assign alu_b_d = instr_use_imm ? instr_imm : regs_q[instr_rs2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      rd_q         <= 3'd0;
      alu_opcode_q <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      flags_q      <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 3'd0;
      wb_data_q    <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid && instr_op != OP_NOP) begin
            state_q      <= EXEC;
            cnt_q        <= 3'(ALU_LAT);
            rd_q         <= instr_rd;
            alu_opcode_q <= instr_op;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= WB;
        end
        WB: begin
          if (rd_q != 3'd0) regs_q[rd_q] <= alu_result;
          flags_q    <= {alu_result == '0, alu_overflow, alu_sign, alu_carry};
          wb_rd_q    <= rd_q;
          wb_data_q  <= alu_result;
          wb_valid_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign flags       = flags_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  // r0 is never written and resets to zero, so a plain array read suffices.
  assign dbg_rd_data = regs_q[dbg_rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: registered add/sub ALU, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_sequencer;

  localparam int ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs1, instr_rs2;
  logic        instr_use_imm;
  logic [15:0] instr_imm;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic        alu_carry, alu_sign, alu_overflow;
  logic [3:0]  flags;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [2:0]  dbg_rd_addr;
  logic [15:0] dbg_rd_data;

  alu_sequencer #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .alu_overflow(alu_overflow),
    .flags(flags), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wb_count = 0;

  // Returns {overflow, sign, carry, result}; 4'h4 = add, 4'h5 = sub (carry = borrow).
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] s;
    logic        ovf;
    s   = 17'd0;
    ovf = 1'b0;
    case (op)
      4'h4: begin
        s   = {1'b0, a} + {1'b0, b};
        ovf = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'h5: begin
        s   = {1'b0, a} - {1'b0, b};
        ovf = (a[15] != b[15]) && (s[15] != a[15]);
      end
      default: ;
    endcase
    return {ovf, s[15], s[16], s[15:0]};
  endfunction

  always @(posedge clk)
    {alu_overflow, alu_sign, alu_carry, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one instruction in flight, result lands ALU_LAT+1 edges after accept.
  logic        m_live = 1'b0;
  logic [15:0] m_regs [8];
  logic        m_pending, m_wb_valid;
  int          m_left;
  logic [2:0]  m_rd, m_wb_rd;
  logic [15:0] m_wb_data;
  logic [3:0]  m_flags, m_alu_op;
  logic [15:0] m_alu_a, m_alu_b;
  logic [18:0] m_out;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_live = 1'b1;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
      m_pending = 1'b0; m_left = 0; m_rd = 3'd0;
      m_wb_valid = 1'b0; m_wb_rd = 3'd0; m_wb_data = 16'd0;
      m_flags = 4'd0; m_alu_op = 4'd0; m_alu_a = 16'd0; m_alu_b = 16'd0;
      m_out = 19'd0;
    end else if (m_live) begin
      m_wb_valid = 1'b0;
      if (m_pending) begin
        m_left--;
        if (m_left == 0) begin
          m_pending = 1'b0;
          if (m_rd != 3'd0) m_regs[m_rd] = m_out[15:0];
          m_flags    = {m_out[15:0] == 16'd0, m_out[18], m_out[17], m_out[16]};
          m_wb_rd    = m_rd;
          m_wb_data  = m_out[15:0];
          m_wb_valid = 1'b1;
        end
      end else if (instr_valid && instr_op != 4'hF) begin
        m_alu_op  = instr_op;
        m_alu_a   = m_regs[instr_rs1];
        m_alu_b   = instr_use_imm ? instr_imm : m_regs[instr_rs2];
        m_out     = alu_fn(m_alu_op, m_alu_a, m_alu_b);
        m_rd      = instr_rd;
        m_pending = 1'b1;
        m_left    = ALU_LAT + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("instr_ready", 16'(instr_ready), 16'(!m_pending));
      check("wb_valid", 16'(wb_valid), 16'(m_wb_valid));
      check("wb_rd", 16'(wb_rd), 16'(m_wb_rd));
      check("wb_data", wb_data, m_wb_data);
      check("flags", 16'(flags), 16'(m_flags));
      check("alu_opcode", 16'(alu_opcode), 16'(m_alu_op));
      check("alu_a", alu_a, m_alu_a);
      check("alu_b", alu_b, m_alu_b);
      check("dbg_rd_data", dbg_rd_data, m_regs[dbg_rd_addr]);
      if (wb_valid === 1'b1) wb_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acc_cyc;

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_use_imm = use_imm; instr_imm = imm; instr_valid = 1'b1;
    dbg_rd_addr = rd;
    for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) tick();
    if (instr_ready !== 1'b1) check("issue_timeout", 16'(instr_ready), 16'd1);
    tick();
    acc_cyc = cyc;
    instr_valid = 1'b0;
  endtask

  task automatic wait_wb(input string name);
    int i;
    for (i = 0; i < 10; i++) begin
      tick();
      #4;
      if (wb_valid === 1'b1) break;
    end
    check({name, "_wb_seen"}, 16'(wb_valid), 16'd1);
    check({name, "_wb_latency"}, 16'(cyc - acc_cyc), 16'(ALU_LAT + 1));
  endtask

  task automatic read_reg(input logic [2:0] idx, input logic [15:0] exp, input string name);
    dbg_rd_addr = idx;
    #1;
    check(name, dbg_rd_data, exp);
  endtask

  int wb0;

  initial begin
    rst = 1'b0;
    instr_valid = 1'b1;
    instr_op = 4'h4; instr_rd = 3'd1; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
    instr_use_imm = 1'b1; instr_imm = 16'h1111; dbg_rd_addr = 3'd0;
    tick();
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;

    // Reset state
    check("rst_ready", 16'(instr_ready), 16'd1);
    check("rst_wb_valid", 16'(wb_valid), 16'd0);
    check("rst_flags", 16'(flags), 16'd0);
    check("rst_alu_a", alu_a, 16'd0);
    check("rst_wb_data", wb_data, 16'd0);
    for (int i = 0; i < 8; i++) read_reg(3'(i), 16'd0, "rst_reg");

    // r1 = r0 + 0x7FFF, then r2 = r1 + 1 -> signed overflow
    issue(4'h4, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
    check("busy_after_accept", 16'(instr_ready), 16'd0);
    wait_wb("add1");
    check("add1_data", wb_data, 16'h7FFF);
    check("add1_rd", 16'(wb_rd), 16'd1);
    check("add1_flags", 16'(flags), 16'b0000);
    tick();
    check("add1_pulse_end", 16'(wb_valid), 16'd0);
    check("ready_after_wb", 16'(instr_ready), 16'd1);

    issue(4'h4, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001);
    wait_wb("add2");
    check("add2_data", wb_data, 16'h8000);
    check("add2_flags", 16'(flags), 16'b0110);
    check("model_r2", m_regs[2], 16'h8000);
    tick();
    read_reg(3'd2, 16'h8000, "r2_value");

    // NOP keeps flags and never pulses wb_valid
    wb0 = wb_count;
    issue(4'hF, 3'd3, 3'd1, 3'd1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("nop_ready", 16'(instr_ready), 16'd1);
      tick();
    end
    check("nop_flags", 16'(flags), 16'b0110);
    check("nop_no_wb", 16'(wb_count - wb0), 16'd0);

    // sub to r0: write discarded, flags/wb still updated
    issue(4'h5, 3'd0, 3'd1, 3'd0, 1'b1, 16'h7FFF);
    wait_wb("sub_r0");
    check("sub_rd", 16'(wb_rd), 16'd0);
    check("sub_data", wb_data, 16'h0000);
    check("sub_flags", 16'(flags), 16'b1000);
    tick();
    read_reg(3'd0, 16'h0000, "r0_zero");

    // Back-to-back valid: one accept every ALU_LAT+2 cycles
    wb0 = wb_count;
    instr_op = 4'h4; instr_rd = 3'd3; instr_rs1 = 3'd3; instr_rs2 = 3'd0;
    instr_use_imm = 1'b1; instr_imm = 16'h0001; instr_valid = 1'b1;
    dbg_rd_addr = 3'd3;
    repeat (9) tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    check("b2b_wb_count", 16'(wb_count - wb0), 16'd3);
    read_reg(3'd3, 16'h0003, "b2b_r3");

    // Reset during EXEC discards the in-flight write
    wb0 = wb_count;
    issue(4'h4, 3'd4, 3'd0, 3'd0, 1'b1, 16'h1234);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("rst_exec_no_wb", 16'(wb_count - wb0), 16'd0);
    check("rst_exec_ready", 16'(instr_ready), 16'd1);
    check("rst_exec_flags", 16'(flags), 16'd0);
    read_reg(3'd4, 16'h0000, "rst_exec_r4");
    read_reg(3'd2, 16'h0000, "rst_exec_r2");

    // Sequencer works again after reset
    issue(4'h4, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0005);
    wait_wb("post_rst");
    check("post_rst_data", wb_data, 16'h0005);
    tick();
    read_reg(3'd5, 16'h0005, "post_rst_r5");
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
